kp_obuf_reader: RTL and testbench

KP_OBUF_READER -- requirements
Module: kp_obuf_reader

---
 rtl/kp_obuf_reader_if.sv | 29 ++
 rtl/kp_obuf_reader.sv | 147 ++++++++++++++
 tb/tb_kp_obuf_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kp_obuf_reader_if.sv
// Handshake bundle between the output-buffer reader, its source FIFO and the
// downstream pixel stream. The slave modport is the reader's view.
interface kp_obuf_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_enable;
    logic                  i_flush;
    logic [DATA_WIDTH-1:0] i_obuf_data;
    logic                  i_obuf_empty;
    logic                  o_obuf_rd;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_sof;
    logic                  o_eol;
    logic                  o_eof;
    logic                  o_frame_done;
    logic                  o_busy;

    modport slave (
        input  i_enable, i_flush, i_obuf_data, i_obuf_empty, i_ready,
        output o_obuf_rd, o_data, o_valid, o_sof, o_eol, o_eof, o_frame_done, o_busy
    );

    modport master (
        output i_enable, i_flush, i_obuf_data, i_obuf_empty, i_ready,
        input  o_obuf_rd, o_data, o_valid, o_sof, o_eol, o_eof, o_frame_done, o_busy
    );
endinterface

// File: rtl/kp_obuf_reader.sv
// Reads one frame of pixels from an output buffer with one-cycle read latency
// and streams it out through a 2-entry skid buffer with sof/eol/eof markers.
module kp_obuf_reader #(
    parameter int LINE_LENGTH = 480,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 16
) (
    input logic             i_clk,
    input logic             i_rstn,
    kp_obuf_reader_if.slave bus
);
    localparam int TOTAL = LINE_LENGTH * LINE_COUNT;
    localparam int CW    = $clog2(LINE_LENGTH) + 1;
    localparam int RW    = $clog2(LINE_COUNT) + 1;
    localparam int NW    = $clog2(TOTAL) + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [NW-1:0]         rd_count;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  frame_done;
    logic                  rd;
    logic                  pop;
    logic                  last_col;
    logic                  last_row;
    logic [2:0]            pending;

    assign pop      = (occ != 2'd0) && bus.i_ready;
    assign last_col = (col == CW'(LINE_LENGTH - 1));
    assign last_row = (row == RW'(LINE_COUNT - 1));

    // An entry retiring this cycle frees its slot in time for the returning
    // read, which is what sustains one pixel per cycle with only two entries.
    assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        rd = 1'b0;
        if (!i_rstn)
            rd = 1'b0;
        else if (bus.i_flush)
            rd = !bus.i_obuf_empty;
        else if (state == ACTIVE && !bus.i_obuf_empty && pending < 3'd2)
            rd = 1'b1;
    end

    // Reads issued while flushing are never marked in flight, so their data is dropped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
        end else if (bus.i_flush) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
        end else begin
            inflight <= rd;
            if (inflight && pop) begin
                if (occ == 2'd1) begin
                    skid0 <= bus.i_obuf_data;
                end else begin
                    skid0 <= skid1;
                    skid1 <= bus.i_obuf_data;
                end
            end else if (pop) begin
                skid0 <= skid1;
                occ   <= occ - 2'd1;
            end else if (inflight) begin
                if (occ == 2'd0)
                    skid0 <= bus.i_obuf_data;
                else
                    skid1 <= bus.i_obuf_data;
                occ <= occ + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col <= '0;
            row <= '0;
        end else if (bus.i_flush) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            rd_count   <= '0;
            frame_done <= 1'b0;
        end else if (bus.i_flush) begin
            state      <= IDLE;
            rd_count   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_enable) begin
                        state    <= ACTIVE;
                        rd_count <= '0;
                    end
                end
                ACTIVE: begin
                    if (rd) begin
                        rd_count <= rd_count + NW'(1);
                        if (rd_count == NW'(TOTAL - 1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && last_col && last_row) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_obuf_rd    = rd;
    assign bus.o_data       = skid0;
    assign bus.o_valid      = (occ != 2'd0);
    assign bus.o_sof        = bus.o_valid && (col == '0) && (row == '0);
    assign bus.o_eol        = bus.o_valid && last_col;
    assign bus.o_eof        = bus.o_valid && last_col && last_row;
    assign bus.o_frame_done = frame_done;
    assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_kp_obuf_reader.sv
// Directed bench for kp_obuf_reader with a 4x2 frame, a behavioural source
// FIFO and a monitor that logs every accepted pixel.
module tb_kp_obuf_reader;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    kp_obuf_reader_if #(.DATA_WIDTH(16)) bus ();

    kp_obuf_reader #(
        .LINE_LENGTH(4),
        .LINE_COUNT (2),
        .DATA_WIDTH (16)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO: read data appears one cycle after the strobe.
    logic [15:0] mem [0:63];
    int          wr_ptr;
    int          rd_ptr;
    initial rd_ptr = 0;
    assign bus.i_obuf_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (bus.o_obuf_rd && (rd_ptr != wr_ptr)) begin
            bus.i_obuf_data <= mem[rd_ptr % 64];
            rd_ptr          <= rd_ptr + 1;
        end
    end

    // Monitor of accepted pixels, frame-done pulses and reads outstanding.
    logic        mon_reset;
    logic [15:0] log_data [0:63];
    logic [2:0]  log_flag [0:63];
    int          log_cyc  [0:63];
    int          log_n, fd_n, fd_cyc, cyc, issued, accepted, max_out, first_rd, first_valid;
    initial cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mon_reset) begin
            log_n = 0; fd_n = 0; fd_cyc = -1; issued = 0; accepted = 0;
            max_out = 0; first_rd = -1; first_valid = -1;
        end else begin
            if (bus.o_obuf_rd && !bus.i_flush) begin
                issued = issued + 1;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.o_valid && first_valid < 0) first_valid = cyc;
            if (bus.o_valid && bus.i_ready && !bus.i_flush && log_n < 64) begin
                log_data[log_n] = bus.o_data;
                log_flag[log_n] = {bus.o_sof, bus.o_eol, bus.o_eof};
                log_cyc[log_n]  = cyc;
                log_n           = log_n + 1;
                accepted        = accepted + 1;
            end
            if (bus.o_frame_done) begin
                fd_n   = fd_n + 1;
                fd_cyc = cyc;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic fl, input logic rdy, input logic mr);
        @(negedge clk);
        bus.i_enable = en;
        bus.i_flush  = fl;
        bus.i_ready  = rdy;
        mon_reset    = mr;
        #1;
    endtask

    task automatic pushPixels(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 64] = base + 16'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic waitLog(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (log_n >= n) break;
        end
        checkOutput("wait_pixels", 32'(log_n >= n), 32'd1);
    endtask

    task automatic waitFrameDone(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("wait_frame_done", 32'(seen), 32'd1);
    endtask

    function automatic logic [2:0] expFlags(input int i);
        return {i == 0, (i % 4) == 3, i == 7};
    endfunction

    task automatic checkFrame(input string tag, input logic [15:0] base);
        checkOutput({tag, "_count"}, 32'(log_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput({tag, "_data"}, 32'(log_data[i]), 32'(base + 16'(i)));
            checkOutput({tag, "_flags"}, 32'(log_flag[i]), 32'(expFlags(i)));
        end
    endtask

    logic pat [0:3];

    initial begin
        checks = 0; errors = 0; wr_ptr = 0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rstn = 1'b0;
        bus.i_enable = 1'b0; bus.i_flush = 1'b0; bus.i_ready = 1'b1; mon_reset = 1'b1;
        pushPixels(16'h0001, 8);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("rst_rd", 32'(bus.o_obuf_rd), 32'd0);
        checkOutput("rst_done", 32'(bus.o_frame_done), 32'd0);
        checkOutput("rst_data", 32'(bus.o_data), 32'd0);
        rstn = 1'b1;

        $display("[TB] frame with i_ready held high");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitFrameDone(60);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkFrame("t1", 16'h0001);
        for (int i = 1; i < 8; i++)
            checkOutput("t1_back_to_back", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        checkOutput("t1_latency", 32'(first_valid - first_rd), 32'd2);
        checkOutput("t1_done_cycle", 32'(fd_cyc - log_cyc[7]), 32'd1);
        checkOutput("t1_done_count", 32'(fd_n), 32'd1);
        checkOutput("t1_busy_after", 32'(bus.o_busy), 32'd0);

        $display("[TB] frame with i_ready pattern 1,0,0,1");
        pushPixels(16'h0001, 8);
        pushPixels(16'h0001, 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (bus.o_frame_done) break;
            bus.i_ready = pat[k % 4];
        end
        checkOutput("t2_done_seen", 32'(bus.o_frame_done), 32'd1);
        checkFrame("t2", 16'h0001);
        checkOutput("t2_max_outstanding", 32'(max_out <= 2), 32'd1);
        bus.i_enable = 1'b1; bus.i_ready = 1'b1; mon_reset = 1'b1;

        $display("[TB] re-arm on frame done, then source underrun");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_rearm_busy", 32'(bus.o_busy), 32'd1);
        waitLog(3, 40);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("t3_gap_rd", 32'(bus.o_obuf_rd), 32'd0);
            checkOutput("t3_gap_valid", 32'(bus.o_valid), 32'd0);
        end
        pushPixels(16'h0004, 5);
        waitFrameDone(60);
        checkFrame("t3", 16'h0001);

        $display("[TB] flush after five pixels");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        pushPixels(16'h0001, 8);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitLog(5, 40);
        bus.i_flush = 1'b1; bus.i_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_flush_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("t4_flush_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t4_flush_drained", 32'(bus.i_obuf_empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("t4_inflight_dropped", 32'(bus.o_valid), 32'd0);
        end
        pushPixels(16'h0011, 8);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitFrameDone(60);
        checkFrame("t4", 16'h0011);

        $display("[TB] reset mid-line");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        pushPixels(16'h0001, 8);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitLog(2, 40);
        rstn = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("t5_rst_flags", 32'({bus.o_sof, bus.o_eol, bus.o_eof}), 32'd0);
        checkOutput("t5_rst_done", 32'(bus.o_frame_done), 32'd0);
        checkOutput("t5_rst_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t5_rst_data", 32'(bus.o_data), 32'd0);
        checkOutput("t5_rst_rd", 32'(bus.o_obuf_rd), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        rstn = 1'b1;
        pushPixels(16'h0021, 4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_no_done", 32'(fd_n), 32'd0);
        checkOutput("t5_idle_busy", 32'(bus.o_busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        waitFrameDone(60);
        checkOutput("t5_count", 32'(log_n), 32'd8);
        checkOutput("t5_first_data", 32'(log_data[0]), 32'h0005);
        checkOutput("t5_first_flags", 32'(log_flag[0]), 32'(3'b100));
        checkOutput("t5_eol_data", 32'(log_data[3]), 32'h0008);
        checkOutput("t5_eol_flags", 32'(log_flag[3]), 32'(3'b010));
        checkOutput("t5_last_data", 32'(log_data[7]), 32'h0024);
        checkOutput("t5_last_flags", 32'(log_flag[7]), 32'(3'b011));

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
